// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional signed-overflow output enabled by defining CLA_OVF_EN.

module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             ci,
    output logic [GROUP-1:0] s
);
    logic carry;

    always_comb begin
        carry = ci;
        s     = '0;
        for (int i = 0; i < GROUP; i++) begin
            s[i]  = p[i] ^ carry;
            carry = g[i] | (p[i] & carry);
        end
    end
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NG  = WIDTH / GROUP;
    localparam int MSB = WIDTH - 1;

    // vld_pipe[1] = stage-1 valid, vld_pipe[2] = stage-2 (output) valid
    logic [2:1]       vld_pipe;
    logic             s1_adv, s2_adv;

    logic [WIDTH-1:0] bp, p_d, g_d;
    logic [NG-1:0]    pg_d, gg_d;
    logic             gacc;

    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_pg, s1_gg;
    logic             s1_c0;
`ifdef CLA_OVF_EN
    logic             s1_amsb;
    logic             ovf_d;
`endif

    logic [NG:0]      gc;
    logic             prod, ck;
    logic [WIDTH-1:0] sum_d;

    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];

    always_comb begin
        bp   = sub ? ~b : b;
        p_d  = a ^ bp;
        g_d  = a & bp;
        pg_d = '0;
        gg_d = '0;
        gacc = 1'b0;
        for (int k = 0; k < NG; k++) begin
            pg_d[k] = &p_d[k*GROUP +: GROUP];
            gacc    = 1'b0;
            for (int i = 0; i < GROUP; i++)
                gacc = g_d[k*GROUP+i] | (p_d[k*GROUP+i] & gacc);
            gg_d[k] = gacc;
        end
    end

    // Each group carry is a flat sum-of-products over lower groups, not a chain.
    always_comb begin
        gc    = '0;
        prod  = 1'b1;
        ck    = 1'b0;
        gc[0] = s1_c0;
        for (int k = 1; k <= NG; k++) begin
            prod = 1'b1;
            ck   = 1'b0;
            for (int j = k - 1; j >= 0; j--) begin
                ck   = ck | (s1_gg[j] & prod);
                prod = prod & s1_pg[j];
            end
            gc[k] = ck | (prod & s1_c0);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p  (s1_p[k*GROUP +: GROUP]),
            .g  (s1_g[k*GROUP +: GROUP]),
            .ci (gc[k]),
            .s  (sum_d[k*GROUP +: GROUP])
        );
    end

`ifdef CLA_OVF_EN
    // Operand signs agree exactly when the MSB propagate bit is clear.
    assign ovf_d = !s1_p[MSB] && (sum_d[MSB] != s1_amsb);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_pg    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef CLA_OVF_EN
            s1_amsb  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_p    <= p_d;
                    s1_g    <= g_d;
                    s1_pg   <= pg_d;
                    s1_gg   <= gg_d;
                    s1_c0   <= sub | cin;
`ifdef CLA_OVF_EN
                    s1_amsb <= a[MSB];
`endif
                end
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    sum  <= sum_d;
                    cout <= gc[NG];
`ifdef CLA_OVF_EN
                    ovf  <= ovf_d;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16): directed cases,
// backpressure, reset mid-flight and a randomized scoreboard run.

module tb_pipelined_cla_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    pipelined_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        longint r;
        if (s) r = longint'(x) - longint'(y) + (longint'(1) << W);
        else   r = longint'(x) + longint'(y) + longint'(ci);
        return r[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic ci, input logic s);
        longint r;
        longint lim;
        lim = longint'(1) << (W - 1);
        if (s) r = longint'($signed(x)) - longint'($signed(y));
        else   r = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        return (r >= lim) || (r < -lim);
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_during: out_valid=%b sum=%h cout=%b in_ready=%b, need 0 0000 0 1",
                     out_valid, sum, cout, in_ready);
        end
`ifdef CLA_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b need 0", ovf); end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: out_valid=%b sum=%h in_ready=%b, need 0 0000 1",
                     out_valid, sum, in_ready);
        end
    endtask

    // One operand set through an empty pipe; checks latency and result.
    task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                           input logic ts, input string name);
        logic [W:0] exp;
        exp = ref_sum(ta, tb_, tci, ts);
        @(negedge clk);
        a = ta; b = tb_; cin = tci; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b need 1", name, in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: out_valid=%b need 0", name, out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid=%b need 1", name, out_valid); end
        checks++;
        if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL %s_result: got cout=%b sum=%h need cout=%b sum=%h", name, cout, sum, exp[W], exp[W-1:0]);
        end
`ifdef CLA_OVF_EN
        checks++;
        if (ovf !== ref_ovf(ta, tb_, tci, ts)) begin
            errors++;
            $display("FAIL %s_ovf: got %b need %b", name, ovf, ref_ovf(ta, tb_, tci, ts));
        end
`endif
    endtask

    task automatic test_directed();
        run_one(16'h0006, 16'h000B, 1'b0, 1'b0, "add");
        run_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "add_wrap");
        run_one(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
        run_one(16'h0007, 16'h0005, 1'b1, 1'b1, "sub_noborrow");
        run_one(16'h0000, 16'h0000, 1'b0, 1'b1, "sub_zero");
        run_one(16'h0FFF, 16'h0001, 1'b0, 1'b0, "add_groupcarry");
    endtask

`ifdef CLA_OVF_EN
    task automatic test_ovf();
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_add");
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, "ovf_sub");
        run_one(16'h7FFE, 16'h0001, 1'b0, 1'b0, "ovf_none");
    endtask
`endif

    task automatic test_backpressure();
        logic [W-1:0] outs[$];
        int           ocyc[$];
        int           acc = 0;
        for (int t = 0; t < 40 && outs.size() < 4; t++) begin
            @(negedge clk);
            out_ready = (t >= 5);
            if (acc < 4) begin
                in_valid = 1'b1; a = W'(acc + 1); b = W'(acc + 1); cin = 1'b0; sub = 1'b0;
            end else in_valid = 1'b0;
            #1;
            if (t == 2) begin
                checks++;
                if (in_ready !== 1'b0 || acc != 2) begin
                    errors++;
                    $display("FAIL bp_full: in_ready=%b accepts=%0d, need 0 and 2", in_ready, acc);
                end
            end
            if (t >= 2 && t < 5) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== 16'h0002) begin
                    errors++;
                    $display("FAIL bp_hold: out_valid=%b sum=%h, need 1 0002", out_valid, sum);
                end
            end
            if (out_valid && out_ready) begin outs.push_back(sum); ocyc.push_back(t); end
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        checks++;
        if (outs.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d results need 4", outs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (outs[i] !== W'(2 * (i + 1))) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h need %h", i, outs[i], W'(2 * (i + 1)));
                end
                if (i > 0) begin
                    checks++;
                    if (ocyc[i] != ocyc[i-1] + 1) begin
                        errors++;
                        $display("FAIL bp_rate[%0d]: cycle %0d after %0d", i, ocyc[i], ocyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_during: out_valid=%b sum=%h in_ready=%b need 0 0000 1", out_valid, sum, in_ready);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_after[%0d]: out_valid=%b sum=%h in_ready=%b need 0 0000 1",
                         i, out_valid, sum, in_ready);
            end
        end
        run_one(16'h1234, 16'h1111, 1'b0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        logic         hold = 1'b0;
        logic [W-1:0] hs;
        logic         hc, r0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== hs || cout !== hc) begin
                    errors++;
                    $display("FAIL rnd_stall_hold: out_valid=%b sum=%h cout=%b need 1 %h %b", out_valid, sum, cout, hs, hc);
                end
            end
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1 r0 = in_ready;
            in_valid = !in_valid;
            #1;
            checks++;
            if (in_ready !== r0) begin
                errors++;
                $display("FAIL rnd_ready_indep: in_ready changed %b->%b with in_valid", r0, in_ready);
            end
            in_valid = !in_valid;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: got sum=%h with no pending operands", sum);
                end else begin
                    e = q.pop_front();
                    if ({cout, sum} !== e[W:0]) begin
                        errors++;
                        $display("FAIL rnd_result: got cout=%b sum=%h need cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
                    end
`ifdef CLA_OVF_EN
                    checks++;
                    if (ovf !== e[W+1]) begin errors++; $display("FAIL rnd_ovf: got %b need %b", ovf, e[W+1]); end
`endif
                end
            end
            if (in_valid && in_ready) q.push_back({ref_ovf(a, b, cin, sub), ref_sum(a, b, cin, sub)});
            hold = out_valid && !out_ready;
            hs   = sum;
            hc   = cout;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() > 0; t++) begin
            @(negedge clk); #1;
            if (out_valid) begin
                e = q.pop_front();
                checks++;
                if ({cout, sum} !== e[W:0]) begin
                    errors++;
                    $display("FAIL rnd_drain: got cout=%b sum=%h need cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost: %0d results never appeared", q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef CLA_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
